fixed_dequantizer_top: RTL
==========================

# fixed_dequantizer_top

Converts a beat of signed integer quantized values back to signed fixed-point using the per-beat scale `max_num` that the quantizer produced. It is the inverse of the quantizer stage and sits after integer compute in the quantized matmul and linear paths, returning results to the fixed-point domain. It is a 2-stage valid/ready pipeline with full throughput. Each beat carries its own scale, so consecutive beats with different scales never mix.

## Interface
- IN_WIDTH, 8, width of each signed quantized element
- SCALE_WIDTH, 8, width of unsigned `max_num`
- SCALE_FRAC_WIDTH, 4, fractional bits of `max_num`
- OUT_WIDTH, 8, width of each signed fixed-point output element
- OUT_FRAC_WIDTH, 4, fractional bits of the output
- IN_PARALLELISM, 4, rows per beat
- IN_SIZE, 1, columns per beat
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  one clock; reset is synchronous and active-low (`rst` low = reset)
- data_in  input  IN_WIDTH x [IN_PARALLELISM*IN_SIZE]  signed quantized elements
- max_num  input  SCALE_WIDTH  unsigned scale; qualified by data_in_valid
- data_in_valid  input  1  beat valid
- data_in_ready  output  1  beat accepted when valid && ready
- data_out  output  OUT_WIDTH x [IN_PARALLELISM*IN_SIZE]  signed fixed-point results
- data_out_valid  output  1  result valid
- data_out_ready  input  1  downstream accepts

## Operation
- Scaling rule, per element: x = q * max_num / 2^(IN_WIDTH-1), with q signed and max_num unsigned.
- Stage 1 (multiply): p = $signed(q) * $signed({1'b0, max_num}). p is IN_WIDTH+SCALE_WIDTH+1 bits, exact.
- Stage 2 (align, round, saturate):
  - S = SCALE_FRAC_WIDTH + IN_WIDTH - 1 - OUT_FRAC_WIDTH.
  - If S > 0: r = (p + 2^(S-1)) >>> S. This is round to nearest, ties toward +inf.
  - If S <= 0: r = p <<< -S, with no rounding.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Intermediate widths must be wide enough that the rounding add never overflows.
- max_num = 0 yields all-zero outputs; this is not a special case.
- q = -2^(IN_WIDTH-1) is legal input and goes through the normal arithmetic.
- All lanes of a beat use the same max_num. Lanes are independent.

## Timing
- Reset (rst low at an edge): both stage valids and data_out_valid clear to 0, data_out clears to all zeros, data_in_ready is 0. Any in-flight beats are dropped.
- data_in_ready is 1 from the first cycle after reset deasserts, while the pipeline has room.
- Latency: a beat accepted at edge N appears with data_out_valid=1 after edge N+2, provided data_out_ready was held high.
- Pipeline advance, per stage:
  - A stage loads when it is empty or when its contents move downstream in the same cycle.
  - data_in_ready = !s1_valid || s2_ready.
  - s2_ready = !data_out_valid || data_out_ready.
  - The ready path is combinational; no skid buffer.
- Throughput: 1 beat per cycle when data_out_ready is held high.
- Backpressure: while data_out_valid && !data_out_ready, data_out is held stable. Stage 1 may still fill once, then data_in_ready drops to 0. No beat is dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal: the stages shift.
- data_out_valid does not depend combinationally on data_out_ready.

## Structure
- Package `dequant_pkg`:
  - localparam function for S.
  - product and round-sum width functions.
  - saturation-bound constants as functions of OUT_WIDTH.
- Sub-module `fixed_dequant_lane`: combinational per-element round, shift and saturate for stage 2. The top generates one instance per lane.
- The pipeline valid/ready registers and the multiply registers live in the top.

## Test plan
Configuration for scenarios 1, 2, 4 and 5: IN_WIDTH=8, SCALE 8/4, OUT 8/4 (S=7).
1. max_num=0x40 (4.0), lanes q={127,-128,1,-1} -> data_out={0x40,0xC0,0x01,0x00}, valid at edge N+2.
2. Saturation, with OUT_FRAC_WIDTH=5 (S=6): max_num=0x7F, q={127,-128,0,64} -> {0x7F,0x80,0x00,0x7F}.
3. Back-to-back beats with alternating max_num=0x10/0x40 and q=64 in every lane, data_out_ready high -> outputs alternate 0x08/0x20. One result per cycle, no mixing of scales.
4. Backpressure: data_out_ready=0 for 5 cycles with 3 beats offered -> data_out held stable, data_in_ready falls after 2 accepts. After release, 3 results emerge in order with no loss.
5. Reset mid-stream: rst low for 1 cycle with 2 beats in flight -> data_out_valid=0 and data_out=0 next cycle, no stale beat emitted afterwards, data_in_ready=1 one cycle after release.
6. Random q and max_num over 1000 beats with random ready -> every output matches a golden model of the scaling rule, including round-half-up and saturation.

Source files
------------

// File: rtl/fixed_dequantizer_pkg.sv
// Shared width/shift helpers for the fixed-point dequantizer.
package dequant_pkg;

  // Right-shift amount that moves q*max_num onto the output fraction grid.
  // A negative value means the product must be shifted left instead.
  function automatic int shift_amt(input int in_w, input int scale_frac_w,
                                   input int out_frac_w);
    return scale_frac_w + in_w - 1 - out_frac_w;
  endfunction

  // Exact signed product width of q (signed) times {1'b0, max_num}.
  function automatic int prod_width(input int in_w, input int scale_w);
    return in_w + scale_w + 1;
  endfunction

  // Width that holds the rounding add (or left shift) without overflow.
  function automatic int round_width(input int p_w, input int s);
    int base;
    base = (p_w > s) ? p_w : s;
    return base + 1 + ((s < 0) ? -s : 0);
  endfunction

  // Saturation bounds of a signed out_w-bit result.
  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/fixed_dequantizer_if.sv
// Valid/ready beat bus of the dequantizer: quantized beat plus scale in,
// fixed-point beat out.
interface fixed_dequantizer_if #(
  parameter int IN_WIDTH    = 8,
  parameter int SCALE_WIDTH = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int LANES       = 4
);
  logic [LANES-1:0][IN_WIDTH-1:0]  data_in;
  logic [SCALE_WIDTH-1:0]          max_num;
  logic                            data_in_valid;
  logic                            data_in_ready;
  logic [LANES-1:0][OUT_WIDTH-1:0] data_out;
  logic                            data_out_valid;
  logic                            data_out_ready;

  modport master (
    output data_in, max_num, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, max_num, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/fixed_dequant_lane.sv
// One output element: round-half-up alignment of the product onto the
// output fraction grid, then saturation to the signed output range.
module fixed_dequant_lane
  import dequant_pkg::*;
#(
  parameter int P_WIDTH   = 17,
  parameter int SHIFT     = 7,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [P_WIDTH-1:0] p,
  output logic        [OUT_WIDTH-1:0] y
);
  localparam int R_WIDTH = round_width(P_WIDTH, SHIFT);
  localparam int R_SHIFT = (SHIFT > 0) ? SHIFT : 0;
  localparam int L_SHIFT = (SHIFT < 0) ? -SHIFT : 0;
  localparam logic signed [R_WIDTH-1:0] HALF =
    (R_SHIFT > 0) ? R_WIDTH'(longint'(1) <<< ((R_SHIFT > 0) ? R_SHIFT - 1 : 0)) : '0;
  localparam logic signed [R_WIDTH-1:0] SAT_HI = R_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [R_WIDTH-1:0] SAT_LO = R_WIDTH'(sat_min(OUT_WIDTH));

  logic signed [R_WIDTH-1:0] p_ext;
  logic signed [R_WIDTH-1:0] r;

  assign p_ext = R_WIDTH'(p);

  // Only one of R_SHIFT/L_SHIFT is ever non-zero, so a single expression
  // covers both the rounding right shift and the exact left shift.
  always_comb begin
    r = ((p_ext + HALF) >>> R_SHIFT) <<< L_SHIFT;
    if (r > SAT_HI)      y = SAT_HI[OUT_WIDTH-1:0];
    else if (r < SAT_LO) y = SAT_LO[OUT_WIDTH-1:0];
    else                 y = r[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/fixed_dequantizer_top.sv
// Two-stage dequantizer: stage 1 registers the exact per-lane products,
// stage 2 registers the rounded/saturated results as data_out.
module fixed_dequantizer_top
  import dequant_pkg::*;
#(
  parameter int IN_WIDTH         = 8,
  parameter int SCALE_WIDTH      = 8,
  parameter int SCALE_FRAC_WIDTH = 4,
  parameter int OUT_WIDTH        = 8,
  parameter int OUT_FRAC_WIDTH   = 4,
  parameter int IN_PARALLELISM   = 4,
  parameter int IN_SIZE          = 1
) (
  input logic                clk,
  input logic                rst,
  fixed_dequantizer_if.slave bus
);
  localparam int LANES   = IN_PARALLELISM * IN_SIZE;
  localparam int S       = shift_amt(IN_WIDTH, SCALE_FRAC_WIDTH, OUT_FRAC_WIDTH);
  localparam int P_WIDTH = prod_width(IN_WIDTH, SCALE_WIDTH);

  logic                            s1_valid;
  logic [LANES-1:0][P_WIDTH-1:0]   s1_p;
  logic [LANES-1:0][OUT_WIDTH-1:0] lane_y;
  logic                            s2_ready;
  logic                            in_ready;

  assign s2_ready          = !bus.data_out_valid || bus.data_out_ready;
  assign in_ready          = rst && (!s1_valid || s2_ready);
  assign bus.data_in_ready = in_ready;

  // Stage 1: accept a beat and register its exact signed products.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.data_in_valid;
      if (bus.data_in_valid) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          s1_p[i] <= P_WIDTH'($signed(bus.data_in[i])) *
                     P_WIDTH'($signed({1'b0, bus.max_num}));
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fixed_dequant_lane #(
      .P_WIDTH   (P_WIDTH),
      .SHIFT     (S),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_lane (
      .p ($signed(s1_p[g])),
      .y (lane_y[g])
    );
  end

  // Stage 2: register the aligned results; hold them under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.data_out_valid <= 1'b0;
      bus.data_out       <= '0;
    end else if (s2_ready) begin
      bus.data_out_valid <= s1_valid;
      if (s1_valid) begin
        bus.data_out <= lane_y;
      end
    end
  end
endmodule
